// File: rtl/insight_pkg.sv
// Shared definitions for the Insight trace capture blocks.
//   - cap_state_e : capture FSM encoding (IDLE/ARMED/CAPTURE/DONE)
//   - MODE_*      : cfg_mode values
//   - tap_rec_t   : packed tap record {drop, ts, flag, data} at default widths
//   - TAP_FLAG_W  : number of tap event flags
package insight_pkg;

  localparam int TAP_FLAG_W = 4;
  localparam int TAP_DATA_W = 32;
  localparam int TAP_TS_W   = 16;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_DONE    = 2'd3
  } cap_state_e;

  localparam logic [1:0] MODE_CONT    = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_TRIG    = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;  // behaves as MODE_CONT

  typedef struct packed {
    logic                  drop;
    logic [TAP_TS_W-1:0]   ts;
    logic [TAP_FLAG_W-1:0] flag;
    logic [TAP_DATA_W-1:0] data;
  } tap_rec_t;

endpackage

// File: rtl/insight_sync_fifo.sv
// Single-clock FIFO with a registered head. Used for trace buffers.
// Ports:
//   clock, reset        : clock, async active-high reset (clears pointers and storage)
//   push, push_data     : write request; accepted when not full, or when full
//                         and a pop happens in the same cycle
//   pop                 : remove head (ignored when empty)
//   full, empty         : occupancy flags
//   head                : current head entry, valid when !empty
module insight_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/insight_tap_capture_ctrl.sv
// Capture sequencer for the core CSR/retire data tap.
// Arms from cfg_*, optionally waits for a flag-mask trigger, timestamps each
// captured tap sample, buffers it and drains it over a valid/ready port.
// Ports:
//   clock, reset                  : clock, async active-high reset
//   tap_valid/tap_data/tap_flag   : tap sample input
//   cfg_enable                    : capture enable level; low forces IDLE
//   cfg_mode                      : 0 cont, 1 one-shot, 2 triggered one-shot, 3 = 0
//   cfg_trig_mask                 : flags that fire the trigger in ARMED
//   cfg_count                     : samples per one-shot (0 = 2^CNT_W)
//   out_valid/out_ready           : trace sink handshake
//   out_data/out_flag/out_ts      : head record
//   out_drop                      : samples were lost just before this record
//   status_state                  : FSM state
//   drop_count                    : saturating lost-sample count
module insight_tap_capture_ctrl
  import insight_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16,
  parameter int CNT_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tap_valid,
  input  logic [DATA_W-1:0]     tap_data,
  input  logic [TAP_FLAG_W-1:0] tap_flag,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_mode,
  input  logic [TAP_FLAG_W-1:0] cfg_trig_mask,
  input  logic [CNT_W-1:0]      cfg_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [TAP_FLAG_W-1:0] out_flag,
  output logic [TS_W-1:0]       out_ts,
  output logic                  out_drop,
  output logic [1:0]            status_state,
  output logic [15:0]           drop_count
);

  localparam logic [1:0] S_IDLE    = CAP_IDLE;
  localparam logic [1:0] S_ARMED   = CAP_ARMED;
  localparam logic [1:0] S_CAPTURE = CAP_CAPTURE;
  localparam logic [1:0] S_DONE    = CAP_DONE;
  localparam int         REC_W     = 1 + TS_W + TAP_FLAG_W + DATA_W;

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             counted;      // one-shot modes stop after cfg_count samples
  logic [TS_W-1:0]  ts;
  logic             pending_drop;
  logic             trig, sample, pop, push, drop, full, empty;
  logic [REC_W-1:0] rec_in, head;

  assign trig = |(tap_flag & cfg_trig_mask);
  // The trigger sample itself is captured, so ARMED samples on trig too.
  assign sample = cfg_enable && tap_valid &&
                  ((state == S_CAPTURE) || ((state == S_ARMED) && trig));

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = sample && (!full || pop);
  assign drop      = sample && !push;
  assign rec_in    = {pending_drop, ts, tap_flag, tap_data};

  assign {out_drop, out_ts, out_flag, out_data} = head;
  assign status_state = state;

  insight_sync_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (rec_in),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      counted   <= 1'b0;
    end else if (!cfg_enable) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= (cfg_mode == MODE_TRIG) ? S_ARMED : S_CAPTURE;
          remaining <= cfg_count;
          counted   <= (cfg_mode == MODE_ONESHOT) || (cfg_mode == MODE_TRIG);
        end
        S_ARMED, S_CAPTURE: begin
          if (sample) begin
            state <= S_CAPTURE;
            if (counted) begin
              // Loaded 0 wraps through 2^CNT_W-1, giving 2^CNT_W samples.
              remaining <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) state <= S_DONE;
            end
          end
        end
        default: state <= state;  // DONE waits for cfg_enable low
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count   <= '0;
      pending_drop <= 1'b0;
    end else begin
      if (drop) begin
        pending_drop <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (push) begin
        pending_drop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_insight_tap_capture_ctrl.sv
module tb_insight_tap_capture_ctrl;
  import insight_pkg::*;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tap_valid = 1'b0;
  logic [31:0] tap_data = '0;
  logic [3:0]  tap_flag = '0;
  logic        cfg_enable = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [3:0]  cfg_trig_mask = '0;
  logic [7:0]  cfg_count = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_flag;
  logic [15:0] out_ts;
  logic        out_drop;
  logic [1:0]  status_state;
  logic [15:0] drop_count;

  insight_tap_capture_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .TS_W(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .tap_valid(tap_valid), .tap_data(tap_data),
    .tap_flag(tap_flag), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_trig_mask(cfg_trig_mask), .cfg_count(cfg_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flag(out_flag), .out_ts(out_ts),
    .out_drop(out_drop), .status_state(status_state), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: capture phase, samples left, FIFO occupancy, drop bookkeeping.
  tap_rec_t    sbq[$];
  int          phase, left, occ, drops_m;
  bit          limited, pend;
  logic [15:0] ts_m;
  // Values the DUT should show between edges (after previous edge).
  int          occ_pre, pre_state, pre_drops;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_step();
    bit smp, pop_m;
    tap_rec_t r;
    occ_pre   = occ;
    pre_state = phase;
    pre_drops = drops_m;
    pop_m = (occ > 0) && out_ready;
    smp = 0;
    if (!cfg_enable) phase = 0;
    else begin
      if (phase == 0) begin
        phase   = (cfg_mode == 2) ? 1 : 2;
        left    = (cfg_count == 0) ? 256 : int'(cfg_count);
        limited = (cfg_mode == 1) || (cfg_mode == 2);
      end else if (phase == 1) smp = tap_valid && ((tap_flag & cfg_trig_mask) != 0);
      else if (phase == 2)     smp = tap_valid;
      if (smp) begin
        phase = 2;
        if (limited) begin
          left--;
          if (left == 0) phase = 3;
        end
      end
    end
    if (smp) begin
      if (occ < DEPTH || pop_m) begin
        r.drop = pend; r.ts = ts_m; r.flag = tap_flag; r.data = tap_data;
        sbq.push_back(r);
        pend = 0;
        occ++;
      end else begin
        pend = 1;
        if (drops_m < 65535) drops_m++;
      end
    end
    if (pop_m) occ--;
  endtask

  task automatic cyc(input bit v, input logic [31:0] d, input logic [3:0] f, input bit rdy);
    tap_valid = v; tap_data = d; tap_flag = f; out_ready = rdy;
    model_step();
    @(posedge clock);
    ts_m = ts_m + 16'd1;
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 4'h0, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_state", 64'(status_state), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_out_ts", 64'(out_ts), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    tap_valid = 0; cfg_enable = 0; out_ready = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    sbq.delete();
    phase = 0; left = 0; limited = 0; occ = 0; drops_m = 0; pend = 0; ts_m = '0;
    occ_pre = 0; pre_state = 0; pre_drops = 0;
  endtask

  // Monitor: compares visible DUT state and head records against the scoreboard.
  initial begin
    tap_rec_t got;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("out_valid", 64'(out_valid), 64'(occ_pre > 0));
        check("status_state", 64'(status_state), 64'(pre_state));
        check("drop_count", 64'(drop_count), 64'(pre_drops));
        if (out_valid) begin
          if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_output: got data %h, expected no record", out_data);
          end else begin
            got = {out_drop, out_ts, out_flag, out_data};
            check("head_record", 64'(got), 64'(sbq[0]));
            if (out_ready) void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    do_reset();

    // Continuous capture, three back-to-back samples.
    cfg_mode = 2'd0; cfg_enable = 1;
    cyc(0, 0, 0, 1);
    idle(5, 1);
    cyc(1, 32'hA, 4'h1, 1);
    cyc(1, 32'hB, 4'h2, 1);
    cyc(1, 32'hC, 4'h3, 1);
    idle(4, 1);
    cfg_enable = 0;
    idle(3, 1);

    // Triggered one-shot: 0001 ignored, 0100 fires, 0000 completes, later samples ignored.
    cfg_mode = 2'd2; cfg_trig_mask = 4'b0100; cfg_count = 8'd2; cfg_enable = 1;
    cyc(0, 0, 0, 1);
    cyc(1, 32'h11, 4'b0001, 1);
    cyc(1, 32'h22, 4'b0100, 1);
    cyc(1, 32'h33, 4'b0000, 1);
    cyc(1, 32'h44, 4'b0100, 1);
    idle(3, 1);
    cfg_enable = 0;
    idle(3, 1);

    // Overflow with sink stalled, then full + pop + push in one cycle.
    cfg_mode = 2'd0; cfg_enable = 1;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'h100 + 32'(i), 4'(i), 0);
    cyc(1, 32'h1FF, 4'hF, 1);
    idle(12, 1);

    // Backpressure toggling every cycle while samples stream in.
    for (int i = 0; i < 24; i++) cyc(i % 3 != 2, 32'h200 + 32'(i), 4'(i), (i % 2) == 1);
    idle(14, 1);
    cfg_enable = 0;
    idle(2, 1);

    // Reset in the middle of a capture with entries queued.
    cfg_mode = 2'd0; cfg_enable = 1;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h300 + 32'(i), 4'h1, 0);
    do_reset();
    cfg_mode = 2'd1; cfg_count = 8'd3; cfg_enable = 1;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 32'h400 + 32'(i), 4'h2, 1);
    idle(4, 1);
    cfg_enable = 0;
    idle(2, 1);

    // Randomized traffic across all modes, masks and counts.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) cfg_enable = !cfg_enable;
      if ($urandom_range(0, 19) == 0) begin
        cfg_mode      = 2'($urandom_range(0, 3));
        cfg_trig_mask = 4'($urandom);
        cfg_count     = 8'($urandom_range(0, 6));
      end
      cyc($urandom_range(0, 1) == 1, $urandom, 4'($urandom), $urandom_range(0, 9) < 7);
    end
    cfg_enable = 0;
    idle(DEPTH + 4, 1);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
